// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM slave with fixed response latency.
// Ports: clk, rst (async active-low), dmem_wr_en/rd_en/addr/wdata in;
//        dmem_valid/rdata, busy, err_range, err_overrun out.
module dmem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_wr_en,
  input  logic        dmem_rd_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_valid,
  output logic [31:0] dmem_rdata,
  output logic        busy,
  output logic        err_range,
  output logic        err_overrun
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        erng_q, erng_d;
  logic        eovr_q, eovr_d;
  logic        ld_q, ld_d;
  logic        ok_q, ok_d;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rd_word_q;

  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          req;
  logic          accept;
  logic          unused_lsb;

  assign word_idx   = dmem_addr[31:2];
  assign mem_idx    = word_idx[AW-1:0];
  assign in_range   = word_idx < 30'(MEM_DEPTH);
  assign unused_lsb = ^dmem_addr[1:0];
  assign req        = dmem_wr_en | dmem_rd_en;
  assign accept     = req && (state_q != WAIT);

  // RAM is never reset; a load snapshots its word on the accept edge
  // so later stores cannot change an in-flight result.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (dmem_wr_en) begin
        if (in_range) mem[mem_idx] <= dmem_wdata;
      end else begin
        rd_word_q <= mem[mem_idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    erng_d  = 1'b0;
    eovr_d  = 1'b0;
    ld_d    = ld_q;
    ok_d    = ok_q;
    unique case (1'b1)
      (state_q == WAIT): begin
        eovr_d = req;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          valid_d = 1'b1;
          erng_d  = ~ok_q;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          ld_d = ~dmem_wr_en;
          ok_d = in_range;
          if (LATENCY == 1) begin
            state_d = RESP;
            valid_d = 1'b1;
            erng_d  = ~in_range;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      erng_q  <= 1'b0;
      eovr_q  <= 1'b0;
      ld_q    <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      erng_q  <= erng_d;
      eovr_q  <= eovr_d;
      ld_q    <= ld_d;
      ok_q    <= ok_d;
    end
  end

  // Stores and out-of-range loads answer with zero data.
  assign dmem_rdata  = (valid_q && ld_q && ok_q) ? rd_word_q : '0;
  assign dmem_valid  = valid_q;
  assign busy        = busy_q;
  assign err_range   = erng_q;
  assign err_overrun = eovr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (latency 2 and 1) against a
// transaction-level model; directed table, corner sequences, random.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr [2];
  logic        rd [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        ebad [2];
  logic        eovr [2];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .dmem_wr_en(wr[0]), .dmem_rd_en(rd[0]),
    .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_valid(valid[0]), .dmem_rdata(rdata[0]),
    .busy(busy[0]), .err_range(ebad[0]),
    .err_overrun(eovr[0])
  );

  dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .dmem_wr_en(wr[1]), .dmem_rd_en(rd[1]),
    .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_valid(valid[1]), .dmem_rdata(rdata[1]),
    .busy(busy[1]), .err_range(ebad[1]),
    .err_overrun(eovr[1])
  );

  logic [31:0] mdl [2][DEPTH];
  int          resp_at [2];
  int          nfree [2];
  int          ovr_at [2];
  logic [31:0] resp_d [2];
  bit          resp_bad [2];
  int          last_vcyc [2];
  logic [31:0] last_rdata [2];
  bit          last_bad [2];
  int          vcnt [2];
  int          cyc;
  int          checks;
  int          failures;
  vec_t        tbl [10];

  function automatic int lat(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      resp_at[k] = -1;
      nfree[k]   = 0;
      ovr_at[k]  = -1;
    end
  endtask

  // One request in flight per responder; a request is taken
  // only once the previous response cycle has been reached.
  task automatic model_apply();
    for (int k = 0; k < 2; k++) begin
      if (wr[k] || rd[k]) begin
        if (cyc >= nfree[k]) begin
          bit bad;
          int idx;
          bad = !(addr[k][31:2] < DEPTH);
          idx = bad ? 0 : int'(addr[k][31:2]);
          if (wr[k]) begin
            if (!bad) mdl[k][idx] = wdata[k];
            resp_d[k] = 32'h0;
          end else begin
            resp_d[k] = bad ? 32'h0 : mdl[k][idx];
          end
          resp_bad[k] = bad;
          resp_at[k]  = cyc + lat(k);
          nfree[k]    = cyc + lat(k);
        end else begin
          ovr_at[k] = cyc + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit ev;
      ev = (resp_at[k] == cyc);
      chk($sformatf("valid%0d", k), valid[k], ev);
      chk($sformatf("rdata%0d", k), rdata[k],
          ev ? resp_d[k] : 32'h0);
      chk($sformatf("err_range%0d", k), ebad[k],
          ev && resp_bad[k]);
      chk($sformatf("err_overrun%0d", k), eovr[k],
          ovr_at[k] == cyc);
      chk($sformatf("busy%0d", k), busy[k],
          cyc < nfree[k]);
      if (valid[k]) begin
        last_vcyc[k]  = cyc;
        last_rdata[k] = rdata[k];
        last_bad[k]   = ebad[k];
        vcnt[k]++;
      end
    end
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      wr[k]    = 1'b0;
      rd[k]    = 1'b0;
      addr[k]  = 32'h0;
      wdata[k] = 32'h0;
    end
  endtask

  task automatic req(input int k, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d);
    wr[k]    = w;
    rd[k]    = r;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  task automatic txn(input int k, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d);
    int acc;
    int n;
    req(k, w, r, a, d);
    acc = cyc;
    tick();
    idle_all();
    n = 0;
    while (last_vcyc[k] <= acc && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("latency%0d", k), last_vcyc[k] - acc, lat(k));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int k = 0; k < 2; k++) begin
      last_vcyc[k] = -1;
      vcnt[k]      = 0;
    end
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0, 32'h11111111, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h11111111, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'(4*DEPTH), 32'h0, 32'h0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'(4*DEPTH), 32'hBAD, 32'h0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h11111111, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 32'h14, 32'h55, 32'h0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 32'h14, 32'h0, 32'h55, 1'b0};

    idle_all();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) begin
        txn(k, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
        chk($sformatf("tbl_rdata%0d_%0d", k, i),
            last_rdata[k], tbl[i].exp_rdata);
        chk($sformatf("tbl_err%0d_%0d", k, i),
            last_bad[k], tbl[i].exp_bad);
      end
    end

    // Request during WAIT is dropped and flagged one cycle later.
    req(0, 1'b0, 1'b1, 32'h10, 32'h0);
    tick();
    req(0, 1'b1, 1'b0, 32'h10, 32'h999);
    tick();
    idle_all();
    chk("ovr_pulse", eovr[0], 1'b1);
    chk("ovr_load", last_rdata[0], 32'hDEADBEEF);
    tick();
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("ovr_noeffect", last_rdata[0], 32'hDEADBEEF);

    // Continuous loads: every LATENCY cycles one is served.
    tick();
    begin
      int v0;
      int v1;
      v0 = vcnt[0];
      v1 = vcnt[1];
      for (int i = 0; i < 8; i++) begin
        for (int k = 0; k < 2; k++)
          req(k, 1'b0, 1'b1, 32'((i % 4) * 4), 32'h0);
        tick();
      end
      idle_all();
      for (int i = 0; i < 3; i++) tick();
      chk("b2b_count0", vcnt[0] - v0, 8 / lat(0));
      chk("b2b_count1", vcnt[1] - v1, 8 / lat(1));
    end

    // Reset while a store is waiting for its response.
    req(0, 1'b1, 1'b0, 32'h18, 32'hCAFE);
    tick();
    idle_all();
    chk("pre_rst_busy", busy[0], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), valid[k], 1'b0);
      chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      chk($sformatf("rst_erng%0d", k), ebad[k], 1'b0);
      chk($sformatf("rst_eovr%0d", k), eovr[k], 1'b0);
    end
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    txn(0, 1'b0, 1'b1, 32'h18, 32'h0);
    chk("rst_store_kept", last_rdata[0], 32'hCAFE);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++)
        txn(k, 1'b1, 1'b0, 32'(i * 4), $urandom);

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        int op;
        int sel;
        logic [29:0] idx;
        logic [31:0] a;
        op  = $urandom_range(0, 5);
        sel = $urandom_range(0, 9);
        if (sel < 8) idx = 30'(sel);
        else if (sel == 8) idx = 30'(DEPTH + $urandom_range(0, 3));
        else idx = 30'h3FFFFFFF;
        a = {idx, 2'($urandom_range(0, 3))};
        unique case (op)
          1: req(k, 1'b0, 1'b1, a, 32'h0);
          2: req(k, 1'b1, 1'b0, a, $urandom);
          3: req(k, 1'b1, 1'b1, a, $urandom);
          default: req(k, 1'b0, 1'b0, 32'h0, 32'h0);
        endcase
      end
      tick();
    end
    idle_all();
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
